shift_reg_ctrl: RTL and testbench

Sequencing controller for the team's 8-bit universal shift register (parallel load, shift right, shift left, serial in/out). It turns the register into a single-channel serializer/deserializer: a transmit command loads a word and shifts it onto a serial line, and a receive command shifts a word in from a serial line. Either direction can be selected per transfer. The register instance stays outside this block; the controller only drives its control and data pins.

---
 rtl/shift_reg_ctrl.sv | 110 +++++++++++
 tb/tb_shift_reg_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_ctrl.sv
// Serializer/deserializer sequencer for an external 8-bit universal shift register.
// Latency: tx done WIDTH+2 cycles after start, rx done WIDTH+1; no backpressure, start only taken in IDLE.
module shift_reg_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             dir,
  input  logic             abort,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             line_in,
  output logic             line_out,
  output logic             line_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_word,
  output logic             reg_load,
  output logic             reg_shift_right,
  output logic             reg_shift_left,
  output logic [WIDTH-1:0] reg_pdata,
  output logic             reg_sin,
  input  logic             reg_sout,
  input  logic [WIDTH-1:0] reg_q
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rx_q, rx_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    data_d  = data_q;
    rx_d    = rx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          dir_d   = dir;
          data_d  = tx_data;
          cnt_d   = '0;
          state_d = mode ? S_SHIFT : S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = abort ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        // Received word only committed when the transfer completes unaborted.
        if (!abort && mode_q) begin
          rx_d = reg_q;
        end
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      rx_q    <= rx_d;
    end
  end

  logic in_shift;
  assign in_shift        = (state_q == S_SHIFT);
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign reg_load        = (state_q == S_LOAD);
  assign reg_pdata       = reg_load ? data_q : '0;
  assign reg_shift_right = in_shift && !dir_q;
  assign reg_shift_left  = in_shift && dir_q;
  assign line_valid      = in_shift && !mode_q;
  assign line_out        = line_valid && reg_sout;
  assign reg_sin         = in_shift && mode_q && line_in;
  assign rx_word         = rx_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl with a behavioural shift register attached and a word-level reference model.
module tb_shift_reg_ctrl;
  localparam int W = 8;

  logic         clk, reset, start, mode, dir, abort, line_in;
  logic [W-1:0] tx_data;
  logic         line_out, line_valid, busy, done;
  logic [W-1:0] rx_word, reg_pdata;
  logic         reg_load, reg_shift_right, reg_shift_left, reg_sin, reg_sout;
  logic [W-1:0] sr;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] rx_exp;

  shift_reg_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .dir(dir), .abort(abort),
    .tx_data(tx_data), .line_in(line_in), .line_out(line_out), .line_valid(line_valid),
    .busy(busy), .done(done), .rx_word(rx_word), .reg_load(reg_load),
    .reg_shift_right(reg_shift_right), .reg_shift_left(reg_shift_left),
    .reg_pdata(reg_pdata), .reg_sin(reg_sin), .reg_sout(reg_sout), .reg_q(sr)
  );

  // External universal shift register as the controller expects it.
  always_ff @(posedge clk) begin
    if (reg_load)             sr <= reg_pdata;
    else if (reg_shift_right) sr <= {reg_sin, sr[W-1:1]};
    else if (reg_shift_left)  sr <= {sr[W-2:0], reg_sin};
  end
  assign reg_sout = reg_shift_left ? sr[W-1] : sr[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; mode = 0; dir = 0; abort = 0; line_in = 0; tx_data = '0;
    #12;
    checks++;
    if ({busy, done, line_out, line_valid, reg_load, reg_shift_right, reg_shift_left, reg_sin} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000000",
        {busy, done, line_out, line_valid, reg_load, reg_shift_right, reg_shift_left, reg_sin});
    end
    checks++;
    if (reg_pdata !== 8'h00 || rx_word !== 8'h00) begin
      errors++; $display("FAIL reset_data: got pdata=%h rx=%h expected 00 00", reg_pdata, rx_word);
    end
    @(negedge clk); reset = 1'b0;
    rx_exp = '0;
    step();
  endtask

  task automatic test_transmit(input logic d, input logic [W-1:0] data);
    logic expb;
    start = 1; mode = 0; dir = d; tx_data = data;
    step();
    start = 0; tx_data = ~data; dir = ~d; mode = 1;
    checks++;
    if ({busy, done, reg_load, reg_shift_right, reg_shift_left, line_valid} !== 6'b101000 || reg_pdata !== data) begin
      errors++; $display("FAIL tx_load: got ctl=%b pdata=%h expected 101000 %h",
        {busy, done, reg_load, reg_shift_right, reg_shift_left, line_valid}, reg_pdata, data);
    end
    step();
    for (int k = 0; k < W; k++) begin
      expb = d ? data[W-1-k] : data[k];
      checks++;
      if (line_out !== expb || {busy, done, line_valid, reg_load, reg_shift_right, reg_shift_left, reg_sin} !== {3'b101, 1'b0, !d, d, 1'b0}) begin
        errors++; $display("FAIL tx_bit%0d: got out=%b ctl=%b expected out=%b ctl=%b", k, line_out,
          {busy, done, line_valid, reg_load, reg_shift_right, reg_shift_left, reg_sin}, expb, {3'b101, 1'b0, !d, d, 1'b0});
      end
      step();
    end
    checks++;
    if ({busy, done, line_valid, line_out, reg_load, reg_shift_right, reg_shift_left} !== 7'b1100000 || rx_word !== rx_exp) begin
      errors++; $display("FAIL tx_done: got ctl=%b rx=%h expected 1100000 %h",
        {busy, done, line_valid, line_out, reg_load, reg_shift_right, reg_shift_left}, rx_word, rx_exp);
    end
    mode = 0; dir = 0;
    step();
    checks++;
    if ({busy, done} !== 2'b00 || rx_word !== rx_exp) begin
      errors++; $display("FAIL tx_idle: got busy=%b done=%b rx=%h expected 0 0 %h", busy, done, rx_word, rx_exp);
    end
  endtask

  // seq[k] is the k-th bit presented on line_in.
  task automatic test_receive(input logic d, input logic [W-1:0] seq);
    logic [W-1:0] exp_word;
    for (int k = 0; k < W; k++) begin
      if (d) exp_word[W-1-k] = seq[k];
      else   exp_word[k] = seq[k];
    end
    start = 1; mode = 1; dir = d; tx_data = W'($urandom);
    step();
    start = 0; mode = 0; dir = ~d;
    for (int k = 0; k < W; k++) begin
      line_in = seq[k];
      #1;
      checks++;
      if ({busy, done, line_valid, reg_load, reg_shift_right, reg_shift_left, reg_sin} !== {4'b1000, !d, d, seq[k]}) begin
        errors++; $display("FAIL rx_bit%0d: got %b expected %b", k,
          {busy, done, line_valid, reg_load, reg_shift_right, reg_shift_left, reg_sin}, {4'b1000, !d, d, seq[k]});
      end
      step();
    end
    line_in = 1'($urandom);
    checks++;
    if ({busy, done, reg_shift_right, reg_shift_left} !== 4'b1100 || rx_word !== rx_exp) begin
      errors++; $display("FAIL rx_done: got ctl=%b rx=%h expected 1100 %h",
        {busy, done, reg_shift_right, reg_shift_left}, rx_word, rx_exp);
    end
    mode = 0; dir = 0;
    step();
    rx_exp = exp_word;
    checks++;
    if ({busy, done} !== 2'b00 || rx_word !== exp_word) begin
      errors++; $display("FAIL rx_word: got busy=%b done=%b rx=%h expected 0 0 %h", busy, done, rx_word, exp_word);
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    logic [W-1:0] data;
    logic expb;
    data = W'($urandom);
    start = 1; mode = 0; dir = 0; tx_data = data;
    step();
    start = 0;
    for (int c = 1; c <= W + 2; c++) begin
      if (done) dones++;
      if (c >= 2 && c <= W + 1) begin
        expb = data[c-2];
        checks++;
        if (line_out !== expb || line_valid !== 1'b1) begin
          errors++; $display("FAIL ign_bit%0d: got %b/%b expected %b/1", c - 2, line_out, line_valid, expb);
        end
      end
      // Competing commands during SHIFT and in the DONE cycle.
      start = (c == 4 || c == W + 2); mode = 1; dir = 1; tx_data = ~data;
      step();
      start = 0;
    end
    checks++;
    if (dones != 1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ign_start: got dones=%0d busy=%b expected dones=1 busy=0", dones, busy);
    end
    mode = 0; dir = 0;
  endtask

  task automatic test_abort();
    logic [W-1:0] prev;
    int late_done = 0;
    prev = rx_exp;
    start = 1; mode = 1; dir = 0;
    step();
    start = 0;
    for (int k = 0; k < 3; k++) begin
      line_in = 1'($urandom);
      step();
    end
    abort = 1; line_in = 1'($urandom);
    step();
    abort = 0;
    checks++;
    if ({busy, done} !== 2'b00 || rx_word !== prev) begin
      errors++; $display("FAIL abort_shift: got busy=%b done=%b rx=%h expected 0 0 %h", busy, done, rx_word, prev);
    end
    for (int c = 0; c < W + 2; c++) begin
      if (done || busy) late_done++;
      step();
    end
    checks++;
    if (late_done != 0 || rx_word !== prev) begin
      errors++; $display("FAIL abort_quiet: got active_cycles=%0d rx=%h expected 0 %h", late_done, rx_word, prev);
    end
    test_transmit(1'b0, 8'h17);
    start = 1; mode = 0; tx_data = 8'h5A;
    step();
    start = 0; abort = 1;
    step();
    abort = 0;
    checks++;
    if ({busy, done, reg_load} !== 3'b000) begin
      errors++; $display("FAIL abort_load: got %b expected 000", {busy, done, reg_load});
    end
  endtask

  task automatic test_reset_mid();
    start = 1; mode = 0; dir = 0; tx_data = 8'hFF;
    step();
    start = 0;
    step(); step(); step();
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, line_out, line_valid, reg_load, reg_shift_right, reg_shift_left, reg_sin} !== 8'h00 || reg_pdata !== 8'h00 || rx_word !== 8'h00) begin
      errors++; $display("FAIL reset_mid: got ctl=%b pdata=%h rx=%h expected 0 00 00",
        {busy, done, line_out, line_valid, reg_load, reg_shift_right, reg_shift_left, reg_sin}, reg_pdata, rx_word);
    end
    rx_exp = '0;
    #1 reset = 1'b0;
    step();
    test_transmit(1'b1, 8'hC3);
  endtask

  initial begin
    test_reset();
    test_transmit(1'b0, 8'h17);
    test_transmit(1'b1, 8'h17);
    test_receive(1'b0, 8'b1010_0101);
    checks++;
    if (rx_word !== 8'hA5) begin
      errors++; $display("FAIL rx_a5: got %h expected a5", rx_word);
    end
    test_receive(1'b1, 8'b1000_0011);
    checks++;
    if (rx_word !== 8'hC1) begin
      errors++; $display("FAIL rx_c1: got %h expected c1", rx_word);
    end
    test_ignore_start();
    test_receive(1'b1, W'($urandom));
    test_abort();
    test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 0) test_transmit(1'($urandom), W'($urandom));
      else                           test_receive(1'($urandom), W'($urandom));
      if ($urandom_range(0, 1) == 1) step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
